// File: rtl/ipml_prefetch_rd_engine_v2_0_pkg.sv
// Shared helpers for the ipml read-side prefetch engine: width math and the
// RAM_LAT/PF_DEPTH legality rule used at elaboration.
package ipml_prefetch_rd_engine_v2_0_pkg;

  localparam int RAM_LAT_MAX = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Skid must cover a full RAM round trip or the stream develops bubbles.
  function automatic bit cfg_legal(input int lat, input int depth);
    return (lat >= 1) && (lat <= RAM_LAT_MAX) && (depth >= 2) &&
           ((depth & (depth - 1)) == 0) && (depth >= lat + 1);
  endfunction

endpackage

// File: rtl/ipml_prefetch_rd_engine_v2_0_skid.sv
// Register-based circular skid buffer; head word is presented combinationally.
module ipml_prefetch_skid_fifo
  import ipml_prefetch_rd_engine_v2_0_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int PF_DEPTH = 4,
  parameter int CNT_W    = clog2(PF_DEPTH + 1)
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  input  logic              clr,
  output logic [DATA_W-1:0] dout,
  output logic              vld,
  output logic [CNT_W-1:0]  count
);
  localparam int PW = clog2(PF_DEPTH);

  logic [DATA_W-1:0] mem_q [PF_DEPTH];
  logic [PW-1:0]     wp_q, rp_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_ok;

  assign pop_ok  = pop & vld;
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop_ok);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < PF_DEPTH; i++) mem_q[i] <= '0;
    end else if (clr) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= din;
        wp_q        <= wp_q + PW'(1);
      end
      if (pop_ok) rp_q <= rp_q + PW'(1);
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[rp_q];
  assign vld   = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/ipml_prefetch_rd_engine_v2_0.sv
// Read-side prefetch: credit-limited RAM read issue, latency-matched return
// pipe and an FWFT skid toward the consumer, with synchronous flush.
module ipml_prefetch_rd_engine_v2_0
  import ipml_prefetch_rd_engine_v2_0_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RAM_LAT  = 1,
  parameter int PF_DEPTH = 4,
  parameter int CNT_W    = clog2(PF_DEPTH + 1)
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              ram_empty,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_rd_data,
  input  logic              flush,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_vld,
  output logic [CNT_W-1:0]  pf_count
);
  if (!cfg_legal(RAM_LAT, PF_DEPTH)) begin : g_bad_cfg
    $error("ipml_prefetch_rd_engine_v2_0: illegal RAM_LAT/PF_DEPTH combination");
  end

  logic [RAM_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W+1:0]   credit_use;
  logic               pop, push;

  assign pop = rd_vld & rd_en;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_LAT; i++) inflight = inflight + CNT_W'(vld_pipe_q[i]);
  end

  // Words held plus words still in the RAM pipe, less the one leaving now.
  assign credit_use = (CNT_W+2)'(pf_count) + (CNT_W+2)'(inflight) - (CNT_W+2)'(pop);
  assign ram_rd_en  = ~rd_rst & ~ram_empty & ~flush & (credit_use < (CNT_W+2)'(PF_DEPTH));

  always_comb begin
    vld_pipe_d    = vld_pipe_q << 1;
    vld_pipe_d[0] = ram_rd_en;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst)     vld_pipe_q <= '0;
    else if (flush) vld_pipe_q <= '0;
    else            vld_pipe_q <= vld_pipe_d;
  end

  assign push = vld_pipe_q[RAM_LAT-1];

  ipml_prefetch_skid_fifo #(
    .DATA_W   (DATA_W),
    .PF_DEPTH (PF_DEPTH),
    .CNT_W    (CNT_W)
  ) u_skid (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
    .push   (push),
    .din    (ram_rd_data),
    .pop    (pop),
    .clr    (flush),
    .dout   (rd_data),
    .vld    (rd_vld),
    .count  (pf_count)
  );

endmodule

// File: tb/tb_ipml_prefetch_rd_engine_v2_0.sv
// Directed bench: three engines (LAT1/D2, LAT2/D4, LAT3/D4) each fed by a
// small SDPRAM + fifo_ctrl model.
module tb_ipml_prefetch_rd_engine_v2_0;
  logic        clk, rst;
  logic [2:0]  ram_empty, ram_rd_en, flush, rd_en, rd_vld, gate;
  logic [31:0] ram_rd_data [3];
  logic [31:0] rd_data [3];
  logic [1:0]  pfc0;
  logic [2:0]  pfc1, pfc2;

  logic [31:0] mem   [3][128];
  logic [31:0] dpipe [3][3];
  int          rptr  [3];
  int          wcnt  [3];
  int          n_checks, n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read issued in cycle c shows on stage L-1 in cycle c+L.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        rptr[k] <= 0;
        for (int s = 0; s < 3; s++) dpipe[k][s] <= '0;
      end else begin
        if (ram_rd_en[k]) begin
          dpipe[k][0] <= mem[k][rptr[k] % 128];
          rptr[k]     <= rptr[k] + 1;
        end
        dpipe[k][1] <= dpipe[k][0];
        dpipe[k][2] <= dpipe[k][1];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      ram_empty[k]   = gate[k] | (rptr[k] >= wcnt[k]);
      ram_rd_data[k] = dpipe[k][k];
    end
  end

  ipml_prefetch_rd_engine_v2_0 #(.DATA_W(32), .RAM_LAT(1), .PF_DEPTH(2)) u_l1 (
    .rd_clk(clk), .rd_rst(rst), .ram_empty(ram_empty[0]), .ram_rd_en(ram_rd_en[0]),
    .ram_rd_data(ram_rd_data[0]), .flush(flush[0]), .rd_en(rd_en[0]),
    .rd_data(rd_data[0]), .rd_vld(rd_vld[0]), .pf_count(pfc0));
  ipml_prefetch_rd_engine_v2_0 #(.DATA_W(32), .RAM_LAT(2), .PF_DEPTH(4)) u_l2 (
    .rd_clk(clk), .rd_rst(rst), .ram_empty(ram_empty[1]), .ram_rd_en(ram_rd_en[1]),
    .ram_rd_data(ram_rd_data[1]), .flush(flush[1]), .rd_en(rd_en[1]),
    .rd_data(rd_data[1]), .rd_vld(rd_vld[1]), .pf_count(pfc1));
  ipml_prefetch_rd_engine_v2_0 #(.DATA_W(32), .RAM_LAT(3), .PF_DEPTH(4)) u_l3 (
    .rd_clk(clk), .rd_rst(rst), .ram_empty(ram_empty[2]), .ram_rd_en(ram_rd_en[2]),
    .ram_rd_data(ram_rd_data[2]), .flush(flush[2]), .rd_en(rd_en[2]),
    .rd_data(rd_data[2]), .rd_vld(rd_vld[2]), .pf_count(pfc2));

  function automatic logic [31:0] pfc(input int k);
    case (k)
      0:       return {30'b0, pfc0};
      1:       return {29'b0, pfc1};
      default: return {29'b0, pfc2};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst = 1'b1; rd_en = '0; flush = '0; gate = '0;
    for (int k = 0; k < 3; k++) wcnt[k] = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset_state();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (ram_rd_en[k] !== 1'b0 || rd_vld[k] !== 1'b0 || rd_data[k] !== 32'h0 || pfc(k) !== 32'd0) begin
        n_errors++;
        $display("FAIL reset_state[%0d]: en=%b vld=%b data=%0h cnt=%0d, want 0/0/0/0",
                 k, ram_rd_en[k], rd_vld[k], rd_data[k], pfc(k));
      end
    end
    tick();
  endtask

  task automatic test_first_word();
    bit exp_en [4];
    bit exp_vld[4];
    exp_en  = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_vld = '{1'b0, 1'b0, 1'b1, 1'b0};
    mem[0][0] = 32'hA5;
    wcnt[0]   = 1;
    for (int c = 0; c < 4; c++) begin
      rd_en[0] = (c == 2);
      @(negedge clk);
      n_checks++;
      if (ram_rd_en[0] !== exp_en[c] || rd_vld[0] !== exp_vld[c]) begin
        n_errors++;
        $display("FAIL first_word c%0d: en=%b vld=%b, want en=%b vld=%b",
                 c, ram_rd_en[0], rd_vld[0], exp_en[c], exp_vld[c]);
      end
      if (c == 2) begin
        n_checks++;
        if (rd_data[0] !== 32'hA5 || pfc(0) !== 32'd1) begin
          n_errors++;
          $display("FAIL first_word_data: data=%0h cnt=%0d, want a5/1", rd_data[0], pfc(0));
        end
      end
      tick();
    end
    rd_en[0] = 1'b0;
  endtask

  task automatic test_throughput();
    bit ev;
    for (int i = 0; i < 64; i++) mem[2][i] = i;
    wcnt[2]  = 64;
    rd_en[2] = 1'b1;
    for (int c = 0; c < 70; c++) begin
      ev = (c >= 4) && (c < 68);
      @(negedge clk);
      n_checks++;
      if (rd_vld[2] !== ev) begin
        n_errors++;
        $display("FAIL throughput_vld c%0d: vld=%b, want %b", c, rd_vld[2], ev);
      end
      if (ev) begin
        n_checks++;
        if (rd_data[2] !== 32'(c - 4)) begin
          n_errors++;
          $display("FAIL throughput_data c%0d: data=%0h, want %0h", c, rd_data[2], c - 4);
        end
      end
      tick();
    end
    rd_en[2] = 1'b0;
  endtask

  task automatic test_backpressure();
    int pulses;
    for (int i = 0; i < 10; i++) mem[1][i] = 32'h100 + i;
    wcnt[1] = 10;
    pulses  = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      pulses += int'(ram_rd_en[1]);
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (pulses != 4 || pfc(1) !== 32'd4 || rd_vld[1] !== 1'b1 || rd_data[1] !== 32'h100) begin
      n_errors++;
      $display("FAIL backpressure_fill: pulses=%0d cnt=%0d vld=%b data=%0h, want 4/4/1/100",
               pulses, pfc(1), rd_vld[1], rd_data[1]);
    end
    tick();
    pulses   = 0;
    rd_en[1] = 1'b1;
    @(negedge clk);
    pulses += int'(ram_rd_en[1]);
    tick();
    rd_en[1] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      pulses += int'(ram_rd_en[1]);
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (pulses != 1 || pfc(1) !== 32'd4 || rd_data[1] !== 32'h101) begin
      n_errors++;
      $display("FAIL backpressure_pop: pulses=%0d cnt=%0d data=%0h, want 1/4/101",
               pulses, pfc(1), rd_data[1]);
    end
    tick();
  endtask

  task automatic test_flush();
    reset_all();
    for (int i = 0; i < 16; i++) mem[1][i] = 32'h200 + i;
    wcnt[1] = 16;
    for (int c = 0; c < 16; c++) begin
      flush[1] = (c == 4) || (c >= 9 && c <= 11);
      @(negedge clk);
      if (c == 4) begin
        n_checks++;
        if (pfc(1) !== 32'd2 || ram_rd_en[1] !== 1'b0) begin
          n_errors++;
          $display("FAIL flush_setup: cnt=%0d en=%b, want 2/0", pfc(1), ram_rd_en[1]);
        end
      end
      if (c >= 9 && c <= 11) begin
        n_checks++;
        if (ram_rd_en[1] !== 1'b0) begin
          n_errors++;
          $display("FAIL flush_issue c%0d: en=%b, want 0", c, ram_rd_en[1]);
        end
      end
      if ((c >= 5 && c <= 7) || (c >= 10 && c <= 14)) begin
        n_checks++;
        if (rd_vld[1] !== 1'b0 || pfc(1) !== 32'd0) begin
          n_errors++;
          $display("FAIL flush_empty c%0d: vld=%b cnt=%0d, want 0/0", c, rd_vld[1], pfc(1));
        end
      end
      if (c == 5 || c == 12) begin
        n_checks++;
        if (ram_rd_en[1] !== 1'b1) begin
          n_errors++;
          $display("FAIL flush_resume c%0d: en=%b, want 1", c, ram_rd_en[1]);
        end
      end
      if (c == 8 || c == 15) begin
        n_checks++;
        if (rd_vld[1] !== 1'b1 || rd_data[1] !== (c == 8 ? 32'h204 : 32'h208)) begin
          n_errors++;
          $display("FAIL flush_next c%0d: vld=%b data=%0h, want 1/%0h",
                   c, rd_vld[1], rd_data[1], (c == 8 ? 32'h204 : 32'h208));
        end
      end
      tick();
    end
    flush[1] = 1'b0;
  endtask

  task automatic test_random(input int k);
    int   lat, dep, mcount, pop_idx, infl;
    logic [2:0] mpipe;
    bit   mvld, mpop, memp, exp_en;
    lat = k + 1;
    dep = (k == 0) ? 2 : 4;
    reset_all();
    for (int i = 0; i < 128; i++) mem[k][i] = 32'h5000 + k * 256 + i;
    wcnt[k] = 128;
    mcount = 0; pop_idx = 0; mpipe = '0;
    for (int c = 0; c < 200; c++) begin
      gate[k]  = c[0];
      rd_en[k] = 1'($urandom_range(1, 0));
      @(negedge clk);
      mvld = (mcount != 0);
      mpop = mvld && rd_en[k];
      infl = 0;
      for (int i = 0; i < lat; i++) infl += int'(mpipe[i]);
      memp   = gate[k] || (rptr[k] >= wcnt[k]);
      exp_en = !memp && ((mcount + infl - int'(mpop)) < dep);
      n_checks++;
      if (ram_rd_en[k] !== exp_en || rd_vld[k] !== mvld || pfc(k) !== 32'(mcount) ||
          pfc(k) > 32'(dep)) begin
        n_errors++;
        $display("FAIL random[%0d] c%0d: en=%b vld=%b cnt=%0d, want en=%b vld=%b cnt=%0d",
                 k, c, ram_rd_en[k], rd_vld[k], pfc(k), exp_en, mvld, mcount);
      end
      if (mvld) begin
        n_checks++;
        if (rd_data[k] !== mem[k][pop_idx]) begin
          n_errors++;
          $display("FAIL random_data[%0d] c%0d: data=%0h, want %0h", k, c, rd_data[k], mem[k][pop_idx]);
        end
      end
      mcount  = mcount + int'(mpipe[lat-1]) - int'(mpop);
      mpipe   = {mpipe[1:0], exp_en};
      pop_idx = pop_idx + int'(mpop);
      tick();
    end
    gate[k]  = 1'b0;
    rd_en[k] = 1'b0;
  endtask

  task automatic test_reset_midstream();
    reset_all();
    for (int i = 0; i < 20; i++) mem[2][i] = 32'h700 + i;
    wcnt[2]  = 20;
    rd_en[2] = 1'b1;
    repeat (8) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (ram_rd_en[2] !== 1'b0 || rd_vld[2] !== 1'b0 || pfc(2) !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_mid: en=%b vld=%b cnt=%0d, want 0/0/0", ram_rd_en[2], rd_vld[2], pfc(2));
    end
    wcnt[2] = 0;
    @(negedge clk);
    n_checks++;
    if (rd_data[2] !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mid_data: data=%0h, want 0", rd_data[2]);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (rd_vld[2] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_stale c%0d: vld=%b, want 0", c, rd_vld[2]);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) mem[2][i] = 32'hB00 + i;
    wcnt[2] = 3;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (rd_vld[2] !== (c >= 4 && c <= 6) ||
          ((c >= 4 && c <= 6) && rd_data[2] !== 32'(32'hB00 + c - 4))) begin
        n_errors++;
        $display("FAIL reset_restart c%0d: vld=%b data=%0h, want vld=%b data=%0h",
                 c, rd_vld[2], rd_data[2], (c >= 4 && c <= 6), 32'hB00 + c - 4);
      end
      tick();
    end
    rd_en[2] = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; rd_en = '0; flush = '0; gate = '0;
    for (int k = 0; k < 3; k++) wcnt[k] = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset_state();
    rst = 1'b0;
    tick();
    test_first_word();
    test_throughput();
    test_backpressure();
    test_flush();
    for (int k = 0; k < 3; k++) test_random(k);
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
